// File: rtl/fp16_align.sv
// Binary16 operand aligner: picks the larger-magnitude operand and right-shifts the
// smaller significand one bit per cycle. Optional sticky tracking under FP16_ALIGN_STICKY_EN.
module fp16_align (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] mant_big,
    output logic [10:0] mant_small,
    output logic [4:0]  exp_out,
    output logic        sign_big,
    output logic        sign_small,
    output logic        sticky,
    output logic        special
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;

    logic [4:0]  exp_a_eff;
    logic [4:0]  exp_b_eff;
    logic [10:0] sig_a;
    logic [10:0] sig_b;
    logic        a_is_big;
    logic [4:0]  exp_big_eff;
    logic [4:0]  exp_small_eff;
    logic [10:0] sig_big_u;
    logic [10:0] sig_small_u;
    logic [4:0]  exp_diff;
    logic [3:0]  shift_amt;
    logic        is_special;
    logic        accept;

    // Subnormals get a zero hidden bit and behave as exponent 1.
    assign exp_a_eff = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
    assign exp_b_eff = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
    assign sig_a     = {a[14:10] != 5'd0, a[9:0]};
    assign sig_b     = {b[14:10] != 5'd0, b[9:0]};

    assign a_is_big      = {exp_a_eff, sig_a} >= {exp_b_eff, sig_b};
    assign exp_big_eff   = a_is_big ? exp_a_eff : exp_b_eff;
    assign exp_small_eff = a_is_big ? exp_b_eff : exp_a_eff;
    assign sig_big_u     = a_is_big ? sig_a : sig_b;
    assign sig_small_u   = a_is_big ? sig_b : sig_a;
    assign exp_diff      = exp_big_eff - exp_small_eff;
    assign is_special    = (a[14:10] == 5'd31) || (b[14:10] == 5'd31);
    assign accept        = in_valid && in_ready;

    // Beyond 11 positions every significand bit is already gone, so the shift saturates.
    always_comb begin
        shift_amt = 4'd0;
        if (is_special)
            shift_amt = 4'd0;
        else if (exp_diff > 5'd11)
            shift_amt = 4'd11;
        else
            shift_amt = exp_diff[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (shift_amt != 4'd0) ? SHIFT : DONE;
            SHIFT:   if (count == 4'd1) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mant_big   <= 11'd0;
            mant_small <= 11'd0;
            exp_out    <= 5'd0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            special    <= 1'b0;
            count      <= 4'd0;
        end else if (accept) begin
            mant_big   <= sig_big_u;
            mant_small <= sig_small_u;
            exp_out    <= exp_big_eff;
            sign_big   <= a_is_big ? a[15] : b[15];
            sign_small <= a_is_big ? b[15] : a[15];
            special    <= is_special;
            count      <= shift_amt;
        end else if (state == SHIFT) begin
            mant_small <= {1'b0, mant_small[10:1]};
            count      <= count - 4'd1;
        end
    end

`ifdef FP16_ALIGN_STICKY_EN
    always_ff @(posedge clk) begin
        if (rst)
            sticky <= 1'b0;
        else if (accept)
            sticky <= 1'b0;
        else if (state == SHIFT)
            sticky <= sticky | mant_small[0];
    end
`else
    assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fp16_align.sv
// Self-checking bench for fp16_align: directed scenarios with literal expectations
// plus randomized pairs checked against an arithmetic alignment model.
module tb_fp16_align;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] mant_big;
    logic [10:0] mant_small;
    logic [4:0]  exp_out;
    logic        sign_big;
    logic        sign_small;
    logic        sticky;
    logic        special;

    logic manual_ready = 1'b0;
    logic rnd_ready = 1'b0;
    logic rand_ready = 1'b0;
    assign out_ready = rand_ready ? rnd_ready : manual_ready;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

`ifdef FP16_ALIGN_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    typedef struct {
        logic [30:0] fields;
        int          dc;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    bit   first_cycle = 1'b1;

    fp16_align dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .exp_out    (exp_out),
        .sign_big   (sign_big),
        .sign_small (sign_small),
        .sticky     (sticky),
        .special    (special)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [30:0] pack(input int mb, input int ms, input int e,
                                         input int sb, input int ss, input int st, input int sp);
        logic [30:0] r;
        r = {mb[10:0], ms[10:0], e[4:0], sb[0], ss[0], st[0], sp[0]};
        return r;
    endfunction

    function automatic logic [30:0] dut_fields();
        return {mant_big, mant_small, exp_out, sign_big, sign_small, sticky, special};
    endfunction

    // Reference: magnitudes as plain integers, alignment as division by a power of two.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
        exp_t r;
        int ex, ey, effx, effy, sigx, sigy, keyx, keyy;
        int effb, effs, sigb, sigs, sb, ss, d, dc, sp, st, ms;
        ex   = int'(x[14:10]);
        ey   = int'(y[14:10]);
        effx = (ex == 0) ? 1 : ex;
        effy = (ey == 0) ? 1 : ey;
        sigx = ((ex != 0) ? 1024 : 0) + int'(x[9:0]);
        sigy = ((ey != 0) ? 1024 : 0) + int'(y[9:0]);
        keyx = effx * 2048 + sigx;
        keyy = effy * 2048 + sigy;
        if (keyx >= keyy) begin
            effb = effx; effs = effy; sigb = sigx; sigs = sigy;
            sb = int'(x[15]); ss = int'(y[15]);
        end else begin
            effb = effy; effs = effx; sigb = sigy; sigs = sigx;
            sb = int'(y[15]); ss = int'(x[15]);
        end
        sp = (ex == 31 || ey == 31) ? 1 : 0;
        d  = effb - effs;
        dc = (sp != 0) ? 0 : ((d > 11) ? 11 : d);
        ms = sigs / (1 << dc);
        st = (STICKY_ON && (sigs % (1 << dc)) != 0) ? 1 : 0;
        r.fields  = pack(sigb, ms, effb, sb, ss, st, sp);
        r.dc      = dc;
        r.acc_cyc = 0;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Compare process: every DONE cycle is checked against the head of the model queue.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            first_cycle = 1'b1;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    reportTimeout("spurious_out_valid");
                end else begin
                    checkOutput("model_fields", 64'(dut_fields()), 64'(exp_q[0].fields));
                    checkOutput("busy_in_ready", 64'(in_ready), 64'd0);
                    if (first_cycle)
                        checkOutput("model_latency", 64'(cyc - exp_q[0].acc_cyc), 64'(1 + exp_q[0].dc));
                    first_cycle = 1'b0;
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        first_cycle = 1'b1;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = model(a, b);
                e.acc_cyc = cyc;
                exp_q.push_back(e);
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb);
        int n;
        n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            reportTimeout("wait_in_ready");
            return;
        end
        in_valid = 1'b1;
        a = va;
        b = vb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    task automatic waitValid(output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) reportTimeout("wait_out_valid");
        lat = n + 1;
    endtask

    task automatic consume();
        manual_ready = 1'b1;
        @(posedge clk); #1;
        manual_ready = 1'b0;
        checkOutput("post_handshake_in_ready", 64'(in_ready), 64'd1);
        checkOutput("post_handshake_out_valid", 64'(out_valid), 64'd0);
    endtask

    function automatic logic [15:0] randOperand();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 7))
            0: v[14:10] = 5'd0;
            1: v[14:10] = 5'd31;
            2: v[14:0]  = 15'd0;
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        int lat;
        logic [15:0] ra;
        logic [15:0] rb;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_fields", 64'(dut_fields()), 64'd0);

        // Pin the model itself with hand-derived values.
        checkOutput("model_pin_1", 64'(model(16'h3C00, 16'h3800).fields), 64'(pack('h400, 'h200, 15, 0, 0, 0, 0)));
        checkOutput("model_pin_3", 64'(model(16'h4900, 16'h0001).fields), 64'(pack('h500, 0, 18, 0, 0, STICKY_ON, 0)));

        applyStimulus(16'h3C00, 16'h3800);
        waitValid(lat);
        checkOutput("d1_latency", 64'(lat), 64'd2);
        checkOutput("d1_fields", 64'(dut_fields()), 64'(pack('h400, 'h200, 15, 0, 0, 0, 0)));
        consume();

        applyStimulus(16'h3800, 16'hBC00);
        waitValid(lat);
        checkOutput("d2_latency", 64'(lat), 64'd2);
        checkOutput("d2_fields", 64'(dut_fields()), 64'(pack('h400, 'h200, 15, 1, 0, 0, 0)));
        consume();

        applyStimulus(16'h4900, 16'h0001);
        waitValid(lat);
        checkOutput("d3_latency", 64'(lat), 64'd12);
        checkOutput("d3_fields", 64'(dut_fields()), 64'(pack('h500, 0, 18, 0, 0, STICKY_ON, 0)));
        consume();

        applyStimulus(16'h3C00, 16'h3C00);
        waitValid(lat);
        checkOutput("bp_latency", 64'(lat), 64'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_fields", 64'(dut_fields()), 64'(pack('h400, 'h400, 15, 0, 0, 0, 0)));
            @(posedge clk); #1;
        end
        consume();

        applyStimulus(16'h4900, 16'h3C00);
        @(posedge clk); #1;
        rst = 1'b1;
        in_valid = 1'b1;
        manual_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        manual_ready = 1'b0;
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_fields", 64'(dut_fields()), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkOutput("abort_no_emit", 64'(out_valid), 64'd0);
        end

        applyStimulus(16'h7C00, 16'h3C00);
        waitValid(lat);
        checkOutput("sp_latency", 64'(lat), 64'd1);
        checkOutput("sp_fields", 64'(dut_fields()), 64'(pack('h400, 'h400, 31, 0, 0, 0, 1)));
        consume();

        rand_ready = 1'b1;
        for (int i = 0; i < 250; i++) begin
            ra = randOperand();
            rb = randOperand();
            if ($urandom_range(0, 3) == 0) begin
                rb[14:10] = ra[14:10] - 5'($urandom_range(0, 3));
            end
            applyStimulus(ra, rb);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end

        for (int n = 0; n < 100 && (exp_q.size() != 0 || out_valid); n++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) reportTimeout("drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp16_align.md
FP16_ALIGN -- requirements
Module: fp16_align

Interface
REQ-001 SHALL have parameters: none; width fixed to IEEE-754 binary16 (1 sign, 5 exponent, 10 fraction).
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept
- a  in  16  operand A
- b  in  16  operand B
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream (11-bit significand adder) accepts
- mant_big  out  11  significand of larger-magnitude operand, hidden bit at [10]
- mant_small  out  11  right-aligned significand of the smaller operand
- exp_out  out  5  effective exponent of the larger operand
- sign_big  out  1  sign of the larger operand
- sign_small  out  1  sign of the smaller operand
- sticky  out  1  OR of bits shifted out of mant_small
- special  out  1  either exponent field == 31

Function
REQ-003 SHALL unpack each operand: hidden bit = 1 if exp != 0, else 0 with effective exponent 1 (subnormal).
REQ-004 SHALL select the larger operand by comparing {eff_exp, significand} unsigned; on equality A is "big".
REQ-005 SHALL compute d = eff_exp_big - eff_exp_small, clamped as d_c = min(d, 11); special forces d_c = 0.
REQ-006 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE:
- IDLE: in_ready=1; on in_valid&in_ready register unpacked operands, load counter with d_c, go to SHIFT if d_c>0, else DONE.
- SHIFT: in_ready=0; each cycle shift mant_small right by 1 with zero fill and decrement the counter; go to DONE when the counter reaches 0 after the shift.
- DONE: out_valid=1, in_ready=0; all outputs held stable until out_valid&out_ready, then go to IDLE.
REQ-007 SHALL assert out_valid exactly 1+d_c cycles after the accept edge when out_ready is not considered.
REQ-008 SHALL use one shift per SHIFT cycle; no barrel shifter.
REQ-009 SHALL hold a, b sampling only on accept; input changes at other times have no effect.
REQ-010 SHALL not accept a new pair in the same cycle that a result is consumed; in_ready rises in the cycle after the handshake, giving a minimum 2-cycle initiation interval.
REQ-011 SHALL ignore out_ready outside DONE.
REQ-012 SHALL pass exp_out, sign_big and sign_small unchanged through SHIFT.
REQ-013 SHALL force special=1 when either exponent field == 31; mant and exp outputs then carry unpacked values unshifted.

Reset
REQ-014 SHALL on rst=1 at a clock edge enter IDLE, aborting any in-flight pair without emitting it.
REQ-015 SHALL reset values: in_ready=1 in the cycle after reset; out_valid=0, mant_big=0, mant_small=0, exp_out=0, sign_big=0, sign_small=0, sticky=0, special=0, counter=0.
REQ-016 SHALL give rst priority over in_valid and out_ready in the same cycle.

Configuration
REQ-017 SHALL honour macro FP16_ALIGN_STICKY_EN:
- defined: sticky clears on accept and ORs in each bit shifted out of mant_small[0].
- undefined: no sticky logic; sticky is tied to 0.

Verification
REQ-018 SHALL be covered by these directed scenarios:
- a=0x3C00, b=0x3800 -> mant_big=0x400, mant_small=0x200, exp_out=15, sign_big=0, sticky=0, out_valid at accept+2.
- a=0x3800, b=0xBC00 -> swap; mant_big=0x400, mant_small=0x200, sign_big=1, sign_small=0, exp_out=15.
- a=0x4900, b=0x0001 -> d=17, d_c=11; mant_big=0x500, mant_small=0x000, exp_out=18, out_valid at accept+12; sticky=1 with macro, 0 without.
- Backpressure: a=0x3C00, b=0x3C00, out_ready=0 for 5 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0; then out_ready=1 -> IDLE and in_ready=1 next cycle.
- rst pulse while in SHIFT (a=0x4900, b=0x3C00) -> next cycle state IDLE, out_valid=0, in_ready=1, all outputs 0; the aborted pair is never emitted.
- a=0x7C00, b=0x3C00 -> special=1, d_c=0, out_valid at accept+1.
